// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-level round-robin arbiter that lets N AXI4-Stream producers share one
// consumer. A grant is locked from the first beat of a packet through its tlast
// beat. The selected beat passes through a single output register and is
// tagged with its source index on m_axis_tid.
//
// Ports:
//   clk, rstn                 clock (rising edge) and synchronous active-low reset
//   s_axis_t*                 N packed input streams; stream i at [i*W +: W]
//   s_axis_tready             per-stream ready; only the granted stream is ever ready
//   m_axis_t*                 registered output stream, tid = source index
//   grant_valid               high while a packet is locked
//   grant_idx                 index of the locked stream, held after the packet ends
// -----------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [N*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [N-1:0]               s_axis_tvalid,
  output logic [N-1:0]               s_axis_tready,
  input  logic [N-1:0]               s_axis_tlast,
  input  logic [N*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [ID_WIDTH-1:0]        m_axis_tid,
  output logic [USER_WIDTH-1:0]      m_axis_tuser,
  output logic                       grant_valid,
  output logic [ID_WIDTH-1:0]        grant_idx
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ID_WIDTH-1:0]     rr_ptr_r;
  logic [ID_WIDTH-1:0]     rr_ptr_nxt_s;
  logic [ID_WIDTH-1:0]     grant_idx_r;
  logic [ID_WIDTH-1:0]     grant_idx_nxt_s;
  logic                    grant_valid_r;
  logic                    grant_valid_nxt_s;

  logic                    pick_found_s;
  logic [ID_WIDTH-1:0]     pick_idx_s;
  logic [ID_WIDTH:0]       cand_s;

  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic [KEEP_WIDTH-1:0]   sel_keep_s;
  logic                    sel_valid_s;
  logic                    sel_last_s;
  logic [USER_WIDTH-1:0]   sel_user_s;

  logic                    out_free_s;
  logic                    beat_acc_s;

  logic [DATA_WIDTH-1:0]   m_tdata_r;
  logic [KEEP_WIDTH-1:0]   m_tkeep_r;
  logic                    m_tvalid_r;
  logic                    m_tlast_r;
  logic [ID_WIDTH-1:0]     m_tid_r;
  logic [USER_WIDTH-1:0]   m_tuser_r;

  // Round-robin scan: first valid requester at rr_ptr, rr_ptr+1, ... with wrap.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (ID_WIDTH+1)'(k);
      if (cand_s >= (ID_WIDTH+1)'(N)) begin
        cand_s = cand_s - (ID_WIDTH+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!pick_found_s && s_axis_tvalid[cand_s[ID_WIDTH-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s[ID_WIDTH-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Select the locked stream's fields.
  always_comb begin
    sel_data_s  = s_axis_tdata[int'(grant_idx_r)*DATA_WIDTH +: DATA_WIDTH];
    sel_keep_s  = s_axis_tkeep[int'(grant_idx_r)*KEEP_WIDTH +: KEEP_WIDTH];
    sel_user_s  = s_axis_tuser[int'(grant_idx_r)*USER_WIDTH +: USER_WIDTH];
    sel_valid_s = s_axis_tvalid[grant_idx_r];
    sel_last_s  = s_axis_tlast[grant_idx_r];
  end

  // The output register can take a beat when empty or when it drains this cycle.
  assign out_free_s = !m_tvalid_r || m_axis_tready;
  assign beat_acc_s = (state_r == ST_BUSY) && sel_valid_s && out_free_s;

  // Ready goes only to the locked stream, and only while the output can accept.
  always_comb begin
    s_axis_tready = '0;
    if (state_r == ST_BUSY) begin
      s_axis_tready[grant_idx_r] = out_free_s;
    end else begin
      s_axis_tready = '0;
    end
  end

  // Next-state logic: arbitrate in IDLE, release the lock on an accepted tlast.
  always_comb begin
    state_nxt_s       = state_r;
    rr_ptr_nxt_s      = rr_ptr_r;
    grant_idx_nxt_s   = grant_idx_r;
    grant_valid_nxt_s = grant_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s       = ST_BUSY;
          grant_idx_nxt_s   = pick_idx_s;
          grant_valid_nxt_s = 1'b1;
        end else begin
          grant_valid_nxt_s = 1'b0;
        end
      end
      ST_BUSY: begin
        if (beat_acc_s && sel_last_s) begin
          state_nxt_s       = ST_IDLE;
          grant_valid_nxt_s = 1'b0;
          // The stream after the one just served gets first look next time.
          if (grant_idx_r == ID_WIDTH'(N - 1)) begin
            rr_ptr_nxt_s = '0;
          end else begin
            rr_ptr_nxt_s = grant_idx_r + ID_WIDTH'(1);
          end
        end else begin
          grant_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s       = ST_IDLE;
        grant_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= '0;
      grant_idx_r   <= '0;
      grant_valid_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      rr_ptr_r      <= rr_ptr_nxt_s;
      grant_idx_r   <= grant_idx_nxt_s;
      grant_valid_r <= grant_valid_nxt_s;
    end
  end

  // Output stage: load on accept, empty on drain, hold stable while stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_tdata_r  <= '0;
      m_tkeep_r  <= '0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tid_r    <= '0;
      m_tuser_r  <= '0;
    end else if (beat_acc_s) begin
      m_tdata_r  <= sel_data_s;
      m_tkeep_r  <= sel_keep_s;
      m_tvalid_r <= 1'b1;
      m_tlast_r  <= sel_last_s;
      m_tid_r    <= grant_idx_r;
      m_tuser_r  <= sel_user_s;
    end else if (m_axis_tready) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tkeep  = m_tkeep_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tlast  = m_tlast_r;
  assign m_axis_tid    = m_tid_r;
  assign m_axis_tuser  = m_tuser_r;
  assign grant_valid   = grant_valid_r;
  assign grant_idx     = grant_idx_r;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed scenarios followed by a randomized phase. Producers are simple
// per-stream packet generators; the reference keeps the arbitration rules as
// plain integers (busy flag, granted index, scan pointer) and the single-entry
// output stage as a queue of expected beats.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 1;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
  } beat_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast;
  logic [N*UW-1:0] s_tuser;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic [UW-1:0]   m_tuser;
  logic            gnt_valid;
  logic [IW-1:0]   gnt_idx;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.N(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tuser(m_tuser), .grant_valid(gnt_valid), .grant_idx(gnt_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  // producers
  int            pk_left[N];
  int            pk_len[N];
  int            beat[N];
  int            len_fixed[N];
  logic [DW-1:0] dat[N];
  bit            incr[N];
  bit            gap[N];
  bit            mrdy;

  // reference
  bit            mb;
  int            mg;
  int            mp;
  beat_t         sb[$];
  int            cnt[N];
  bit            prev_stall;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int new_len(input int i);
    return (len_fixed[i] != 0) ? len_fixed[i] : 1 + int'($urandom % 4);
  endfunction

  task automatic start(input int i, input int npk, input int len, input bit inc, input logic [DW-1:0] d0);
    pk_left[i]   = npk;
    len_fixed[i] = len;
    pk_len[i]    = new_len(i);
    beat[i]      = 0;
    incr[i]      = inc;
    dat[i]       = d0;
    gap[i]       = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]           = (pk_left[i] > 0) && !gap[i];
      s_tdata[i*DW +: DW]   = dat[i];
      s_tkeep[i*KW +: KW]   = dat[i][KW-1:0] ^ 8'h5A;
      s_tuser[i*UW +: UW]   = dat[i][DW-1];
      s_tlast[i]            = (beat[i] == pk_len[i] - 1);
    end
    m_tready = mrdy;
  endtask

  // One clock cycle: drive, check ready, advance reference, check outputs.
  task automatic tick();
    logic [N-1:0] er;
    bit           rst_now;
    bit           lastb;
    beat_t        b;
    drive();
    #1;
    rst_now = !rstn;
    er = '0;
    for (int i = 0; i < N; i++) er[i] = mb && (i == mg) && (sb.size() == 0 || mrdy);
    check("s_tready", 64'(s_tready), 64'(er));
    if (m_tvalid === 1'b1 && m_tready && m_tlast === 1'b1) cnt[m_tid]++;
    prev_stall = (m_tvalid === 1'b1) && !m_tready;
    prev_data  = m_tdata;
    if (rst_now) begin
      mb = 1'b0; mg = 0; mp = 0; sb.delete(); prev_stall = 1'b0;
      for (int i = 0; i < N; i++) begin pk_left[i] = 0; beat[i] = 0; end
    end else begin
      if (sb.size() > 0 && mrdy) void'(sb.pop_front());
      if (mb) begin
        if (s_tvalid[mg] && er[mg]) begin
          lastb  = (beat[mg] == pk_len[mg] - 1);
          b.data = dat[mg];
          b.keep = dat[mg][KW-1:0] ^ 8'h5A;
          b.user = dat[mg][DW-1];
          b.last = lastb;
          b.id   = IW'(mg);
          sb.push_back(b);
          if (lastb) begin
            pk_left[mg]--; beat[mg] = 0; pk_len[mg] = new_len(mg);
            mb = 1'b0; mp = (mg + 1) % N;
          end else begin
            beat[mg]++;
          end
          dat[mg] = incr[mg] ? dat[mg] + 64'd1 : {$urandom, $urandom};
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!mb && s_tvalid[(mp + k) % N]) begin mb = 1'b1; mg = (mp + k) % N; end
        end
      end
    end
    @(posedge clk);
    #1;
    check("m_tvalid", 64'(m_tvalid), 64'(sb.size() > 0));
    check("grant_valid", 64'(gnt_valid), 64'(mb));
    check("grant_idx", 64'(gnt_idx), 64'(mg));
    if (sb.size() > 0) begin
      check("m_tdata", m_tdata, sb[0].data);
      check("m_tkeep", 64'(m_tkeep), 64'(sb[0].keep));
      check("m_tlast", 64'(m_tlast), 64'(sb[0].last));
      check("m_tuser", 64'(m_tuser), 64'(sb[0].user));
      check("m_tid", 64'(m_tid), 64'(sb[0].id));
    end
    if (prev_stall) check("stall_stable", m_tdata, prev_data);
    if (rst_now) begin
      check("rst_tdata", m_tdata, 64'd0);
      check("rst_tkeep", 64'(m_tkeep), 64'd0);
      check("rst_tlast", 64'(m_tlast), 64'd0);
      check("rst_tid", 64'(m_tid), 64'd0);
      check("rst_tuser", 64'(m_tuser), 64'd0);
    end
  endtask

  function automatic bit pending();
    bit p = mb || (sb.size() > 0);
    for (int i = 0; i < N; i++) p = p || (pk_left[i] > 0);
    return p;
  endfunction

  task automatic run_until_idle(input string tag, input int budget);
    int c = 0;
    while (pending() && c < budget) begin tick(); c++; end
    n_vec++;
    assert (c < budget) else begin
      n_err++;
      $error("FAIL %s: observed timeout after %0d cycles expected drain", tag, c);
    end
  endtask

  task automatic run_until_beat(input int i, input int target, input int budget);
    int c = 0;
    while (beat[i] != target && c < budget) begin tick(); c++; end
    n_vec++;
    assert (c < budget) else begin
      n_err++;
      $error("FAIL wait_beat: observed beat %0d expected %0d", beat[i], target);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pk_left[i] = 0; pk_len[i] = 1; beat[i] = 0; len_fixed[i] = 1;
      dat[i] = '0; incr[i] = 1'b0; gap[i] = 1'b0; cnt[i] = 0;
    end
    mb = 1'b0; mg = 0; mp = 0; prev_stall = 1'b0; mrdy = 1'b1;
    rstn = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("reset_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_tready", 64'(s_tready), 64'd0);
    check("reset_gvalid", 64'(gnt_valid), 64'd0);
    check("reset_tdata", m_tdata, 64'd0);
    rstn = 1'b1;
    tick();

    // single requester: stream 2, beats A,B,C
    start(2, 1, 3, 1'b1, 64'hA);
    run_until_idle("single", 20);

    // fairness: 4 streams x 10 packets of 2 beats
    for (int i = 0; i < N; i++) begin cnt[i] = 0; start(i, 10, 2, 1'b0, {$urandom, $urandom}); end
    run_until_idle("fair", 400);
    for (int i = 0; i < N; i++) check("fair_share", 64'(cnt[i]), 64'd10);

    // backpressure on a 4-beat packet from stream 1
    start(1, 1, 4, 1'b1, 64'h100);
    mrdy = 1'b1;
    tick(); tick();
    mrdy = 1'b1; tick();
    mrdy = 1'b0; tick();
    mrdy = 1'b0; tick();
    mrdy = 1'b1; tick();
    run_until_idle("bp", 30);

    // wrap and skip
    start(3, 1, 1, 1'b0, 64'h33);
    run_until_idle("wrap3", 10);
    start(1, 1, 1, 1'b0, 64'h11);
    tick();
    check("skip_to_1", 64'(gnt_idx), 64'd1);
    run_until_idle("wrap1", 10);
    start(0, 1, 1, 1'b0, 64'h00);
    start(2, 1, 1, 1'b0, 64'h22);
    tick();
    check("ptr2_grant", 64'(gnt_idx), 64'd2);
    run_until_idle("wrap02", 20);

    // mid-packet reset, then stream 3 first
    start(0, 1, 5, 1'b1, 64'h500);
    run_until_beat(0, 2, 20);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    start(3, 1, 2, 1'b0, 64'h300);
    tick();
    check("post_rst_grant", 64'(gnt_idx), 64'd3);
    run_until_idle("rst3", 20);

    // lock: stream 0 stalls mid-packet while stream 1 waits
    start(0, 1, 4, 1'b1, 64'h700);
    start(1, 1, 1, 1'b0, 64'h800);
    run_until_beat(0, 2, 20);
    gap[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("lock_no_ready1", 64'(s_tready[1]), 64'd0);
      check("lock_grant", 64'(gnt_idx), 64'd0);
    end
    gap[0] = 1'b0;
    run_until_idle("lock", 30);

    // randomized traffic
    for (int i = 0; i < N; i++) len_fixed[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pk_left[i] == 0 && ($urandom % 8) == 0)
          start(i, 1 + int'($urandom % 3), 0, 1'b0, {$urandom, $urandom});
        gap[i] = (($urandom % 4) == 0);
      end
      mrdy = (($urandom % 4) != 0);
      tick();
    end
    for (int i = 0; i < N; i++) gap[i] = 1'b0;
    mrdy = 1'b1;
    run_until_idle("rand_drain", 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
